// File: rtl/sm_clk_pkg.sv
// Shared types for the CPU clock generator: FSM states, mode encodings, exponent clamp.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sm_clk_pkg;

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_HIGH      = 2'd1,
        S_IDLE      = 2'd2,
        S_STEP_HIGH = 2'd3
    } clk_state_e;

    localparam logic MODE_FREE = 1'b0;
    localparam logic MODE_STEP = 1'b1;

    // Keeps the half-period exponent inside the divider counter.
    function automatic int unsigned clamp_exp(input int unsigned e, input int unsigned max_e);
        return (e > max_e) ? max_e : e;
    endfunction

endpackage

// File: rtl/sm_step_debouncer.sv
// Step-button conditioner: 2-flop synchroniser followed by a stable-count filter.
// Latency: 2 sync cycles + (2^DEB_W - 1) stable cycles before level_o flips; press_o in that same cycle.
// Backpressure: none; press_o is a single-cycle pulse that is lost if not consumed.
// Ports: clk_i/rst_i clock and async active-high reset, btn_i raw button,
//        level_o accepted (debounced) level, press_o one-cycle pulse on accepted 0->1.
module sm_step_debouncer #(
    parameter int unsigned DEB_W = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    logic [1:0]       sync_q;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d, deb_cnt_inc;
    logic             level_q, level_d;
    logic             press_q, press_d;

    always_comb begin
        deb_cnt_d   = '0;
        level_d     = level_q;
        deb_cnt_inc = deb_cnt_q + DEB_W'(1);
        // Count only while the synced input disagrees with the accepted level;
        // any bounce back to the accepted level restarts the count.
        if (sync_q[1] != level_q) begin
            if (deb_cnt_inc == '1) begin
                level_d   = ~level_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_inc;
            end
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q    <= '0;
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_i};
            deb_cnt_q <= deb_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/sm_clk_ctrl.sv
// CPU clock generator: power-of-two free-run divider or single-step from a debounced button.
// Latency: inputs act 2 cycles after the pin; clkOut/clkEn/cycles are registered.
// Backpressure: none; enable=0 freezes the divider and FSM, steps arriving while frozen are dropped.
// Ports: clkIn board clock, rst async active-high reset, devide divide select, enable run/freeze,
//        stepMode 0 free-run / 1 single-step, stepBtn raw button,
//        clkOut generated clock, clkEn pulse on clkOut 0->1, cycles rising-edge count.
module sm_clk_ctrl
    import sm_clk_pkg::*;
#(
    parameter int unsigned SHIFT = 16,
    parameter int unsigned DIV_W = 4,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned DEB_W = 16,
    parameter int unsigned CYC_W = 32
) (
    input  logic             clkIn,
    input  logic             rst,
    input  logic [DIV_W-1:0] devide,
    input  logic             enable,
    input  logic             stepMode,
    input  logic             stepBtn,
    output logic             clkOut,
    output logic             clkEn,
    output logic [CYC_W-1:0] cycles
);

    localparam int unsigned       MAX_EXP   = CNT_W - 1;
    localparam int unsigned       STEP_EXP  = clamp_exp(SHIFT, MAX_EXP);
    localparam logic [CNT_W-1:0]  STEP_TERM = (CNT_W'(1) << STEP_EXP) - CNT_W'(1);

    logic [DIV_W-1:0] dev_s1_q, dev_s2_q;
    logic [1:0]       en_sync_q, mode_sync_q;
    logic             en_s, mode_s;

    clk_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, free_term;
    logic [DIV_W-1:0] div_act_q, div_d;
    logic             clk_q, clk_d;
    logic             clk_en_q, rise;
    logic [CYC_W-1:0] cycles_q, cycles_d;
    int unsigned      free_exp;

    logic btn_level, btn_press, step_press;

    sm_step_debouncer #(.DEB_W(DEB_W)) u_deb (
        .clk_i   (clkIn),
        .rst_i   (rst),
        .btn_i   (stepBtn),
        .level_o (btn_level),
        .press_o (btn_press)
    );

    // Press is only honoured while the accepted level is still high.
    assign step_press = btn_press & btn_level;
    assign en_s       = en_sync_q[1];
    assign mode_s     = mode_sync_q[1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_act_q;
        free_exp  = clamp_exp(SHIFT + 32'(div_act_q), MAX_EXP);
        free_term = (CNT_W'(1) << free_exp) - CNT_W'(1);

        if (en_s) begin
            unique case (state_q)
                S_LOW: begin
                    // Mode change beats a coincident terminal count: no high pulse.
                    if (mode_s == MODE_STEP) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == free_term) begin
                        state_d = S_HIGH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (cnt_q == free_term) begin
                        // New divide value only takes effect on a fresh low half.
                        cnt_d   = '0;
                        div_d   = dev_s2_q;
                        state_d = (mode_s == MODE_STEP) ? S_IDLE : S_LOW;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_IDLE: begin
                    if (mode_s == MODE_FREE) begin
                        state_d = S_LOW;
                        cnt_d   = '0;
                        div_d   = dev_s2_q;
                    end else if (step_press) begin
                        state_d = S_STEP_HIGH;
                        cnt_d   = '0;
                    end
                end
                S_STEP_HIGH: begin
                    // Presses seen here are simply ignored.
                    if (cnt_q == STEP_TERM) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = S_LOW;
            endcase
        end

        clk_d    = (state_d == S_HIGH) || (state_d == S_STEP_HIGH);
        rise     = clk_d & ~clk_q;
        cycles_d = cycles_q + CYC_W'(rise);
    end

    always_ff @(posedge clkIn or posedge rst) begin
        if (rst) begin
            dev_s1_q    <= '0;
            dev_s2_q    <= '0;
            en_sync_q   <= '0;
            mode_sync_q <= '0;
            state_q     <= S_LOW;
            cnt_q       <= '0;
            div_act_q   <= '0;
            clk_q       <= 1'b0;
            clk_en_q    <= 1'b0;
            cycles_q    <= '0;
        end else begin
            dev_s1_q    <= devide;
            dev_s2_q    <= dev_s1_q;
            en_sync_q   <= {en_sync_q[0], enable};
            mode_sync_q <= {mode_sync_q[0], stepMode};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_act_q   <= div_d;
            clk_q       <= clk_d;
            clk_en_q    <= rise;
            cycles_q    <= cycles_d;
        end
    end

    assign clkOut = clk_q;
    assign clkEn  = clk_en_q;
    assign cycles = cycles_q;

endmodule
